// File: rtl/mem_access_master.sv
// mem_access_master
//   Requester side of a 128x8 synchronous data memory. It accepts single-beat
//   writes and 1..8 beat sequential reads on a valid/ready request port. It
//   drives the memory address, data and write enable. Read data and
//   write/error completions come back on a response port that has no
//   backpressure. A request whose address range falls outside the memory is
//   rejected with an error response and never reaches the memory.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (accepted when both are high)
//   req_write             1 = single-beat write, 0 = read burst
//   req_addr, req_len     start address; read beats minus one
//   req_wdata             write data
//   resp_valid            one-cycle pulse per read beat or per completion
//   resp_rdata            read data (passthrough of mem_data_out)
//   resp_last, resp_error final response of a request; range-violation flag
//   busy                  high whenever the FSM is not idle
//   mem_address, mem_data_in, mem_write, mem_data_out   memory side
//   dbg_state             current FSM state encoding
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and never while
// reset is asserted. req_* is sampled only on that edge. resp_valid is a
// plain pulse, and the consumer must take it in the same cycle.
module mem_access_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 128,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_last,
  output logic                  resp_error,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_ISSUE = 3'd1,
    S_RD_DRAIN = 3'd2,
    S_WR       = 3'd3,
    S_WR_RESP  = 3'd4,
    S_ERR      = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [LEN_WIDTH:0]    cnt_q, cnt_d;      // read beats still to issue after the current one
  logic                  issued_q, issued_d; // an address was presented last cycle

  logic                  accept;
  logic [ADDR_WIDTH:0]   rd_end;
  logic                  wr_err;
  logic                  rd_err;

  // The range check uses one extra bit so that addr+len cannot wrap.
  assign rd_end = {1'b0, req_addr} + (ADDR_WIDTH+1)'(req_len);
  assign wr_err = {1'b0, req_addr} >= DEPTH_W;
  assign rd_err = rd_end >= DEPTH_W;

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    issued_d = (state_q == S_RD_ISSUE);
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_write) begin
            if (wr_err) begin
              state_d = S_ERR;
            end else begin
              state_d = S_WR;
              addr_d  = req_addr;
              wdata_d = req_wdata;
            end
          end else begin
            if (rd_err) begin
              state_d = S_ERR;
            end else begin
              state_d = S_RD_ISSUE;
              addr_d  = req_addr;
              cnt_d   = {1'b0, req_len};
            end
          end
        end
      end
      S_RD_ISSUE: begin
        // The last address stays on the bus while its data drains.
        if (cnt_q == '0) begin
          state_d = S_RD_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - (LEN_WIDTH+1)'(1);
        end
      end
      S_WR:       state_d = S_WR_RESP;
      S_RD_DRAIN: state_d = S_IDLE;
      S_WR_RESP:  state_d = S_IDLE;
      S_ERR:      state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign mem_write   = (state_q == S_WR);
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

  // Read data arrives one cycle after its address. The first issue cycle
  // therefore has nothing to return, and the drain cycle returns the final beat.
  assign resp_valid = (state_q == S_ERR) || (state_q == S_WR_RESP) ||
                      (state_q == S_RD_DRAIN) ||
                      ((state_q == S_RD_ISSUE) && issued_q);
  assign resp_last  = (state_q == S_ERR) || (state_q == S_WR_RESP) ||
                      (state_q == S_RD_DRAIN);
  assign resp_error = (state_q == S_ERR);
  assign resp_rdata = mem_data_out;

endmodule
